hififo_tpc_arbiter: RTL and testbench
=====================================

// Module: hififo_tpc_arbiter
// PURPOSE
//  Round-robin arbiter between TPC_CH to-PC FIFO channels and the single PCIe TX write-request port.
//  Grants one ready channel per burst and streams BURST_WORDS 64-bit words from its RAM (1-cycle read latency).
//  Output is a valid/ready stream with first/last flags and channel tag.
//  Replaces the fixed single-channel tpc hookup between hififo_controller, hififo_tpc_fifo instances and pcie_tx.
// PARAMETERS
//  TPC_CH       4   number of to-PC channels (1..8)
//  BURST_WORDS  16  64-bit words per write burst (power of 2, 2..64)
//  CH_W         3   width of channel index outputs (>= clog2(TPC_CH), min 1)
// PORTS
//  clock         in   1             system clock
//  reset_n       in   1             asynchronous reset, active low
//  ch_enable     in   TPC_CH        channel enabled by controller
//  ch_ready      in   TPC_CH        channel holds >= BURST_WORDS words and host space for one burst
//  ch_read       out  TPC_CH        one-hot word read strobe to the granted channel FIFO
//  read_offset   out  clog2(BW)     word index within burst, presented with ch_read
//  ch_data       in   64*TPC_CH     channel RAM data, channel k at [64k+63:64k], valid 1 cycle after ch_read
//  wr_valid      out  1             burst word valid to pcie_tx
//  wr_ready      in   1             pcie_tx accepts word when wr_valid & wr_ready
//  wr_data       out  64            burst word
//  wr_first      out  1             word 0 of burst
//  wr_last       out  1             word BURST_WORDS-1 of burst
//  wr_channel    out  CH_W          channel owning current burst
//  burst_done    out  1             1-cycle pulse when last word accepted
//  done_channel  out  CH_W          channel of completed burst, valid with burst_done
// BEHAVIOUR
//  Reset (async assert, sync deassert expected upstream): every output 0, state IDLE, rr pointer 0, buffers empty.
//  FSM states: IDLE, STREAM, DRAIN.
//   IDLE: req = ch_enable & ch_ready. If req != 0, pick first set bit searching cyclically from rr_ptr.
//     Register grant, set rr_ptr = grant+1 (mod TPC_CH), go STREAM. Otherwise stay.
//   STREAM: issue reads, offset 0..BURST_WORDS-1, one per cycle while credit allows; after last read -> DRAIN.
//   DRAIN: wait until last word accepted; pulse burst_done; -> IDLE.
//  Read flow control: 2-entry output skid FIFO. Read issued only if (entries + in-flight reads) < 2.
//   With wr_ready held high, one word per cycle sustained; no word ever dropped or duplicated.
//  ch_read: exactly one bit high, only for granted channel, only in STREAM; 0 otherwise.
//  Latency: req sampled in IDLE at cycle T -> ch_read and read_offset=0 at T+1 -> wr_valid, wr_first at T+2.
//  Burst of BW words with wr_ready=1: burst_done at T+BW+1. Next grant is sampled the cycle after burst_done.
//   Idle gap between bursts: 2 cycles.
//  wr_valid & wr_data/flags/wr_channel held stable until accepted; wr_valid never deasserts without acceptance.
//  Grant held for the full burst. ch_enable or ch_ready dropping mid-burst does NOT truncate; the burst completes.
//  Requests arriving mid-burst wait; fairness: a continuously requesting channel is served within TPC_CH bursts.
//  Single requester: granted back-to-back indefinitely.
//  Request from channel >= TPC_CH impossible by width; rr_ptr wraps TPC_CH-1 -> 0.
//  read_offset counts in clog2(BURST_WORDS) bits, wraps naturally; wr_last decoded from output-side counter.
//  Reset asserted mid-burst: immediate return to IDLE, outputs 0, partial burst discarded. No burst_done is issued.
// TESTING
//  1 ch_ready=4'b0001, wr_ready=1, BW=16 -> 16 words, offsets 0..15, wr_first@word0, wr_last@word15, burst_done@T+17
//  2 ch_ready=4'b1111 held, rr_ptr=0 -> grants 0,1,2,3,0 in order; wr_channel and done_channel match
//  3 wr_ready toggling 1010..., random stall -> data equals RAM model sequence, no loss/dup; wr_valid held while stalled
//  4 ch2 busy; drop ch_enable[2] at word 5 -> all 16 words still sent, then no ch2 grant while disabled
//  5 reset_n low at word 7 -> outputs 0 same cycle; after release, ch_ready=4'b0100 starts fresh burst offset 0, ch 2
//  6 TPC_CH=1, BW=2 -> continuous bursts with 2-cycle gap; wr_first/wr_last alternate

Source files
------------

// File: rtl/hififo_tpc_arbiter_if.sv
// Burst write-request stream from the to-PC arbiter into pcie_tx.
interface hififo_tpc_arbiter_if #(
    parameter int CH_W = 3
) ();
    logic            wr_valid;
    logic            wr_ready;
    logic [63:0]     wr_data;
    logic            wr_first;
    logic            wr_last;
    logic [CH_W-1:0] wr_channel;

    modport master (output wr_valid, wr_data, wr_first, wr_last, wr_channel, input wr_ready);
    modport slave  (input wr_valid, wr_data, wr_first, wr_last, wr_channel, output wr_ready);
endinterface

// File: rtl/hififo_tpc_arbiter.sv
// Round-robin arbiter streaming fixed-length bursts from the to-PC channel RAMs into pcie_tx.
//   state    | meaning
//   S_IDLE   | sample requests, grant next channel cyclically from rr pointer
//   S_STREAM | issue one RAM read per cycle while the skid buffer has room
//   S_DRAIN  | all reads issued, wait for last word to be accepted
module hififo_tpc_arbiter #(
    parameter int TPC_CH      = 4,
    parameter int BURST_WORDS = 16,
    parameter int CH_W        = 3
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [TPC_CH-1:0]              ch_enable,
    input  logic [TPC_CH-1:0]              ch_ready,
    output logic [TPC_CH-1:0]              ch_read,
    output logic [$clog2(BURST_WORDS)-1:0] read_offset,
    input  logic [64*TPC_CH-1:0]           ch_data,
    hififo_tpc_arbiter_if.master           wr,
    output logic                           burst_done,
    output logic [CH_W-1:0]                done_channel
);
    localparam int OFF_W = $clog2(BURST_WORDS);
    localparam int PTR_W = (TPC_CH > 1) ? $clog2(TPC_CH) : 1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BURST_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_q, rr_d, grant_q, grant_d;
    logic [OFF_W-1:0] rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
    logic             inflight_q, inflight_d;
    logic [63:0]      fifo_mem_q [2];
    logic [63:0]      fifo_mem_d [2];
    logic             fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;

    logic [TPC_CH-1:0] req;
    logic              found;
    logic [PTR_W-1:0]  pick;
    int                idx;
    logic              issue, head_valid, valid, accept, push, pop, last_word;
    logic [63:0]       ram_word, out_word;

    always_comb begin
        req   = ch_enable & ch_ready;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < TPC_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= TPC_CH) idx = idx - TPC_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PTR_W'(idx);
            end
        end
    end

    // Words in the skid buffer plus the read in flight never exceed two.
    always_comb begin
        issue      = (state_q == S_STREAM) && (({1'b0, fifo_cnt_q} + {2'b00, inflight_q}) < 3'd2);
        ram_word   = ch_data[int'(grant_q)*64 +: 64];
        head_valid = (fifo_cnt_q != 2'd0);
        valid      = head_valid | inflight_q;
        out_word   = head_valid ? fifo_mem_q[fifo_rd_q] : ram_word;
        accept     = valid & wr.wr_ready;
        pop        = accept & head_valid;
        push       = inflight_q & ~(accept & ~head_valid);
        last_word  = (out_cnt_q == LAST_OFF);

        inflight_d = issue;
        rd_cnt_d   = issue  ? rd_cnt_q + 1'b1  : rd_cnt_q;
        out_cnt_d  = accept ? out_cnt_q + 1'b1 : out_cnt_q;
        fifo_mem_d = fifo_mem_q;
        if (push) fifo_mem_d[fifo_wr_q] = ram_word;
        fifo_wr_d  = push ? ~fifo_wr_q : fifo_wr_q;
        fifo_rd_d  = pop  ? ~fifo_rd_q : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

        ch_read     = issue ? (TPC_CH'(1) << grant_q) : '0;
        read_offset = issue ? rd_cnt_q : '0;

        wr.wr_valid   = valid;
        wr.wr_data    = valid ? out_word : '0;
        wr.wr_first   = valid & (out_cnt_q == '0);
        wr.wr_last    = valid & last_word;
        wr.wr_channel = valid ? CH_W'(grant_q) : '0;
        burst_done    = accept & last_word;
        done_channel  = burst_done ? CH_W'(grant_q) : '0;
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    rr_d    = (int'(pick) == TPC_CH - 1) ? '0 : pick + 1'b1;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: if (issue && (rd_cnt_q == LAST_OFF)) state_d = S_DRAIN;
            S_DRAIN:  if (burst_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            rr_q          <= '0;
            grant_q       <= '0;
            rd_cnt_q      <= '0;
            out_cnt_q     <= '0;
            inflight_q    <= 1'b0;
            fifo_mem_q[0] <= '0;
            fifo_mem_q[1] <= '0;
            fifo_rd_q     <= 1'b0;
            fifo_wr_q     <= 1'b0;
            fifo_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            rd_cnt_q   <= rd_cnt_d;
            out_cnt_q  <= out_cnt_d;
            inflight_q <= inflight_d;
            fifo_mem_q <= fifo_mem_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_hififo_tpc_arbiter.sv
// Randomized bench for hififo_tpc_arbiter against a burst-level arbitration and credit model.
module tb_hififo_tpc_arbiter;
    localparam int TPC_CH = 4;
    localparam int BW     = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]   ch_enable = '0, ch_ready = '0, ch_read;
    logic [3:0]   read_offset;
    logic [255:0] ch_data = '0;
    logic         burst_done;
    logic [2:0]   done_channel;
    hififo_tpc_arbiter_if #(.CH_W(3)) wr_if ();

    hififo_tpc_arbiter #(.TPC_CH(4), .BURST_WORDS(16), .CH_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .ch_enable(ch_enable), .ch_ready(ch_ready),
        .ch_read(ch_read), .read_offset(read_offset), .ch_data(ch_data), .wr(wr_if),
        .burst_done(burst_done), .done_channel(done_channel));

    logic        en1 = 1'b0, rdy1 = 1'b1, ch_read1, read_offset1, burst_done1, done_channel1;
    logic [63:0] ch_data1 = 64'h0000_0000_00C0_FFEE;
    hififo_tpc_arbiter_if #(.CH_W(1)) wr1_if ();

    hififo_tpc_arbiter #(.TPC_CH(1), .BURST_WORDS(2), .CH_W(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .ch_enable(en1), .ch_ready(rdy1),
        .ch_read(ch_read1), .read_offset(read_offset1), .ch_data(ch_data1), .wr(wr1_if),
        .burst_done(burst_done1), .done_channel(done_channel1));

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] word_of(int k, int n);
        return {8'(8'hA0 + k), 24'(n), (32'(n) * 32'h9E3779B9) ^ (32'(k) * 32'h85EBCA6B)};
    endfunction

    // Channel RAMs: word n of channel k is word_of(k, n); a reset rewinds to what was accepted.
    int acc_cnt [4] = '{default: 0};
    int rcnt    [4] = '{default: 0};
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) rcnt[k] <= acc_cnt[k];
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ch_read[k]) begin
                    ch_data[k*64 +: 64] <= word_of(k, rcnt[k]);
                    rcnt[k] <= rcnt[k] + 1;
                end
            end
        end
    end

    bit          m_busy = 0, prev_stall = 0, exp_valid, can_read, acc;
    int          m_g = 0, m_rr = 0, m_words = 0, m_reads = 0, m_gcyc = 0, m_dcyc = 0, n_bursts = 0, cidx;
    logic [63:0] prev_data;
    logic [3:0]  req_s;
    int          glog [$];

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_ch_read", ch_read, 0);
            chk("rst_read_offset", read_offset, 0);
            chk("rst_wr_valid", wr_if.wr_valid, 0);
            chk("rst_wr_data", wr_if.wr_data, 0);
            chk("rst_flags", {wr_if.wr_first, wr_if.wr_last, wr_if.wr_channel}, 0);
            chk("rst_done", {burst_done, done_channel}, 0);
            m_busy = 0; m_rr = 0; prev_stall = 0;
        end else if (!m_busy) begin
            chk("idle_ch_read", ch_read, 0);
            chk("idle_wr_valid", wr_if.wr_valid, 0);
            chk("idle_done", burst_done, 0);
            prev_stall = 0;
            req_s = ch_enable & ch_ready;
            if (req_s != 0) begin
                for (int i = 0; i < TPC_CH; i++) begin
                    cidx = (m_rr + i) % TPC_CH;
                    if (req_s[cidx]) begin m_g = cidx; break; end
                end
                m_rr = (m_g + 1) % TPC_CH;
                m_busy = 1; m_words = 0; m_reads = 0; m_gcyc = cyc;
                glog.push_back(m_g);
            end
        end else begin
            exp_valid = (m_reads > m_words);
            can_read  = (m_reads < BW) && (m_reads - m_words < 2);
            chk("ch_read", ch_read, can_read ? (4'b0001 << m_g) : 4'b0000);
            if (can_read) begin
                chk("read_offset", read_offset, m_reads);
                m_reads++;
            end
            chk("wr_valid", wr_if.wr_valid, exp_valid);
            if (exp_valid) begin
                chk("wr_data", wr_if.wr_data, word_of(m_g, acc_cnt[m_g]));
                chk("wr_first", wr_if.wr_first, m_words == 0);
                chk("wr_last", wr_if.wr_last, m_words == BW - 1);
                chk("wr_channel", wr_if.wr_channel, m_g);
            end
            if (prev_stall) chk("stall_hold", wr_if.wr_data, prev_data);
            acc = wr_if.wr_valid && wr_if.wr_ready;
            chk("burst_done", burst_done, acc && (m_words == BW - 1));
            if (acc && (m_words == BW - 1)) chk("done_channel", done_channel, m_g);
            prev_stall = wr_if.wr_valid && !wr_if.wr_ready;
            prev_data  = wr_if.wr_data;
            if (acc) begin
                acc_cnt[m_g]++;
                m_words++;
                if (m_words == BW) begin m_busy = 0; m_dcyc = cyc; n_bursts++; end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
    endtask

    int base, gsz, a2, ii;
    int exp_g [5] = '{0, 1, 2, 3, 0};

    initial begin
        wr_if.wr_ready = 1'b0;
        wr1_if.wr_ready = 1'b1;
        tick(1);
        do_reset();

        // Single requester, full-rate sink: pin latency from grant sample to burst_done.
        wr_if.wr_ready = 1'b1; ch_enable = 4'hF; ch_ready = 4'b0001;
        for (ii = 0; ii < 100 && n_bursts < 1; ii++) tick(1);
        ch_ready = 4'b0000;
        chk("t1_timeout", n_bursts >= 1, 1);
        chk("t1_done_latency", m_dcyc - m_gcyc, 17);
        chk("t1_words", acc_cnt[0], 16);

        // All channels requesting from a fresh pointer.
        tick(1);
        do_reset();
        glog.delete();
        base = n_bursts;
        ch_ready = 4'hF;
        for (ii = 0; ii < 300 && n_bursts < base + 5; ii++) tick(1);
        ch_ready = 4'b0000;
        gsz = glog.size();
        chk("t2_grant_count", gsz >= 5, 1);
        if (gsz >= 5) for (int i = 0; i < 5; i++) chk("t2_grant_order", glog[i], exp_g[i]);

        // Alternating then random backpressure with random requests.
        ch_ready = 4'hF;
        for (int i = 0; i < 200; i++) begin wr_if.wr_ready = (i % 2 == 0); tick(1); end
        for (int i = 0; i < 2500; i++) begin
            wr_if.wr_ready = ($urandom_range(0, 3) != 0);
            ch_ready  = 4'($urandom);
            ch_enable = 4'($urandom) | 4'($urandom);
            tick(1);
        end
        wr_if.wr_ready = 1'b1; ch_ready = 4'b0000; ch_enable = 4'hF;
        for (ii = 0; ii < 200 && m_busy; ii++) tick(1);
        chk("t3_drain_timeout", m_busy, 0);

        // Disable a channel mid-burst: the burst still completes, then no more grants.
        a2 = acc_cnt[2];
        ch_ready = 4'b0100;
        for (ii = 0; ii < 100 && !(m_busy && m_g == 2 && m_words == 5); ii++) tick(1);
        chk("t4_reach_word5", m_words, 5);
        ch_enable[2] = 1'b0;
        for (ii = 0; ii < 100 && m_busy; ii++) tick(1);
        chk("t4_burst_len", acc_cnt[2] - a2, 16);
        gsz = glog.size();
        tick(50);
        chk("t4_no_regrant", glog.size(), gsz);

        // Reset in the middle of a burst, then a fresh burst on channel 2.
        ch_enable = 4'hF;
        for (ii = 0; ii < 100 && !(m_busy && m_words == 7); ii++) tick(1);
        chk("t5_reach_word7", m_words, 7);
        reset_n = 1'b0;
        #4;
        chk("t5_async_valid", wr_if.wr_valid, 0);
        tick(2);
        glog.delete();
        reset_n = 1'b1;
        for (ii = 0; ii < 20 && glog.size() < 1; ii++) tick(1);
        chk("t5_regrant", glog.size() >= 1, 1);
        if (glog.size() >= 1) chk("t5_grant_ch", glog[0], 2);
        ch_ready = 4'b0000;
        for (ii = 0; ii < 100 && m_busy; ii++) tick(1);
        chk("t5_finish", m_busy, 0);

        // Single channel, two-word bursts: period of four cycles.
        en1 = 1'b1;
        @(negedge clock);
        for (ii = 0; ii < 30 && !wr1_if.wr_valid; ii++) @(negedge clock);
        chk("t6_start", wr1_if.wr_valid, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t6_valid", wr1_if.wr_valid, (i % 4) < 2);
            chk("t6_first", wr1_if.wr_first, (i % 4) == 0);
            chk("t6_last", wr1_if.wr_last, (i % 4) == 1);
            chk("t6_done", {burst_done1, done_channel1}, {(i % 4) == 1, 1'b0});
            chk("t6_read", {ch_read1, read_offset1}, {((i % 4) == 0) || ((i % 4) == 3), (i % 4) == 0});
            if (wr1_if.wr_valid) chk("t6_data", {wr1_if.wr_data, wr1_if.wr_channel}, {ch_data1, 1'b0});
            @(negedge clock);
        end
        en1 = 1'b0;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
